// File: rtl/c2c_pkg.sv
// Shared types and requester indices for the c2c memory arbiter.
package c2c_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_DR, BUSY_DW} arb_state_t;

  typedef struct packed {
    logic                        we;
    logic [pipeline::XLEN/8-1:0] sel;
    logic [pipeline::XLEN-1:0]   addr;
    logic [pipeline::XLEN-1:0]   wdata;
  } c2c_req_t;

  localparam int unsigned NREQ   = 3;
  localparam int unsigned REQ_I  = 0;
  localparam int unsigned REQ_DR = 1;
  localparam int unsigned REQ_DW = 2;
endpackage

// File: rtl/pipeline.sv
// Core-wide pipeline constants shared by the bus-side blocks.
package pipeline;
  localparam int unsigned XLEN = 32;
endpackage

// File: rtl/c2c_mem_arbiter_prio_sel.sv
// Masked fixed-priority picker (dw > dr > instr) producing a one-hot grant.
module c2c_prio_sel
  import c2c_pkg::*;
(
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] mask_i,
  output logic [NREQ-1:0] gnt_o
);
  logic [NREQ-1:0] elig;

  always_comb begin
    elig  = req_i & ~mask_i;
    gnt_o = '0;
    if (elig[REQ_DW])      gnt_o[REQ_DW] = 1'b1;
    else if (elig[REQ_DR]) gnt_o[REQ_DR] = 1'b1;
    else if (elig[REQ_I])  gnt_o[REQ_I]  = 1'b1;
  end
endmodule

// File: rtl/c2c_mem_arbiter.sv
// Arbitrates instr read, data read and data write onto one req/ack memory port.
// Define C2C_ARB_TIMEOUT_EN to add a BUSY watchdog and the sticky timeout_err output.
module c2c_mem_arbiter
  import c2c_pkg::*;
#(
  parameter int unsigned XLEN = pipeline::XLEN
`ifdef C2C_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_re,
  input  logic [XLEN/8-1:0] instr_sel,
  input  logic [XLEN-1:0]   instr_addr,
  output logic              instr_ack,
  output logic [31:0]       instr_data,
  input  logic              dr_re,
  input  logic [XLEN/8-1:0] dr_sel,
  input  logic [XLEN-1:0]   dr_addr,
  output logic              dr_ack,
  output logic [XLEN-1:0]   dr_data,
  input  logic              dw_we,
  input  logic [XLEN/8-1:0] dw_sel,
  input  logic [XLEN-1:0]   dw_addr,
  input  logic [XLEN-1:0]   dw_data,
  output logic              dw_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_sel,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata
`ifdef C2C_ARB_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);
  arb_state_t      state_q, state_d;
  c2c_req_t        req_q, req_d;
  logic            mem_req_q, mem_req_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] mask_q, mask_d;
  logic [XLEN-1:0] dr_data_q, dr_data_d;
  logic [31:0]     instr_data_q, instr_data_d;
  logic [NREQ-1:0] req_vec, gnt, busy_oh;
  logic [XLEN-1:0] rsp_data;
  logic            done, to_hit;

  assign req_vec[REQ_I]  = instr_re;
  assign req_vec[REQ_DR] = dr_re;
  assign req_vec[REQ_DW] = dw_we;

  c2c_prio_sel u_prio (
    .req_i  (req_vec),
    .mask_i (mask_q),
    .gnt_o  (gnt)
  );

`ifdef C2C_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            timeout_err_q, timeout_err_d;

  always_comb begin
    to_hit        = (state_q != IDLE) && !mem_ack && (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    cnt_d         = (state_q == IDLE || done) ? '0 : cnt_q + 1'b1;
    timeout_err_d = timeout_err_q | to_hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    mem_req_d    = mem_req_q;
    ack_d        = '0;
    dr_data_d    = dr_data_q;
    instr_data_d = instr_data_q;
    busy_oh      = '0;
    case (state_q)
      BUSY_I:  busy_oh[REQ_I]  = 1'b1;
      BUSY_DR: busy_oh[REQ_DR] = 1'b1;
      BUSY_DW: busy_oh[REQ_DW] = 1'b1;
      default: ;
    endcase
    done     = (state_q != IDLE) && (mem_ack || to_hit);
    rsp_data = to_hit ? '1 : mem_rdata;

    if (state_q == IDLE) begin
      if (gnt[REQ_DW]) begin
        req_d   = '{we: 1'b1, sel: dw_sel, addr: dw_addr, wdata: dw_data};
        state_d = BUSY_DW;
      end else if (gnt[REQ_DR]) begin
        req_d   = '{we: 1'b0, sel: dr_sel, addr: dr_addr, wdata: '0};
        state_d = BUSY_DR;
      end else if (gnt[REQ_I]) begin
        req_d   = '{we: 1'b0, sel: instr_sel, addr: instr_addr, wdata: '0};
        state_d = BUSY_I;
      end
      mem_req_d = |gnt;
    end else if (done) begin
      mem_req_d = 1'b0;
      state_d   = IDLE;
      ack_d     = busy_oh;
      if (busy_oh[REQ_DR]) dr_data_d    = rsp_data;
      if (busy_oh[REQ_I])  instr_data_d = rsp_data[31:0];
    end
    // The requester still sees its request asserted during the ack cycle.
    mask_d = ack_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      req_q        <= '0;
      mem_req_q    <= 1'b0;
      ack_q        <= '0;
      mask_q       <= '0;
      dr_data_q    <= '0;
      instr_data_q <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      mem_req_q    <= mem_req_d;
      ack_q        <= ack_d;
      mask_q       <= mask_d;
      dr_data_q    <= dr_data_d;
      instr_data_q <= instr_data_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = req_q.we;
  assign mem_sel    = req_q.sel;
  assign mem_addr   = req_q.addr;
  assign mem_wdata  = req_q.wdata;
  assign instr_ack  = ack_q[REQ_I];
  assign dr_ack     = ack_q[REQ_DR];
  assign dw_ack     = ack_q[REQ_DW];
  assign dr_data    = dr_data_q;
  assign instr_data = instr_data_q;
endmodule

// File: doc/c2c_mem_arbiter.md
Name: c2c_mem_arbiter

Overview:
- Sits directly downstream of the core's registered bus outputs (instruction read, data read, data write).
- Arbitrates the three c2c requesters onto a single unified memory port with a req/ack handshake.
- Returns ack and read data to the requester that won.
- Lets a single-ported RAM or external memory model serve the whole core.

Parameters:
- XLEN, pipeline::XLEN (32), data/address width.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- instr_re  in  1  instruction read request, level, held until instr_ack
- instr_sel  in  XLEN/8  instruction byte select
- instr_addr  in  XLEN  instruction address
- instr_ack  out  1  one-cycle instruction completion pulse
- instr_data  out  32  instruction word, valid with instr_ack
- dr_re  in  1  data read request, level
- dr_sel  in  XLEN/8  data read byte select
- dr_addr  in  XLEN  data read address
- dr_ack  out  1  one-cycle data read completion pulse
- dr_data  out  XLEN  read data, valid with dr_ack
- dw_we  in  1  data write request, level
- dw_sel  in  XLEN/8  write byte strobes
- dw_addr  in  XLEN  write address
- dw_data  in  XLEN  write data
- dw_ack  out  1  one-cycle write completion pulse
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read
- mem_sel  out  XLEN/8  byte strobes
- mem_addr  out  XLEN  memory address
- mem_wdata  out  XLEN  write data
- mem_ack  in  1  one-cycle memory completion pulse
- mem_rdata  in  XLEN  read data, valid with mem_ack

Behaviour:
- Reset (async, active-high): all outputs 0; FSM = IDLE; hold-off mask cleared.
- FSM states: IDLE, BUSY_I, BUSY_DR, BUSY_DW.
- IDLE:
  - Samples unmasked requests.
  - Fixed priority: dw > dr > instr.
  - On a winner, latches addr/sel/wdata/we into mem_* registers, asserts mem_req next cycle, and enters BUSY_x.
  - Latency from request seen to mem_req high: 1 cycle.
- BUSY_x:
  - mem_* outputs hold stable until mem_ack.
  - On mem_ack, in the same edge: mem_req drops, the matching x_ack pulses for exactly 1 cycle, read data is registered into x_data, and FSM returns to IDLE.
  - Total latency from request seen to x_ack: 1 + memory latency + 1 cycles.
- Hold-off:
  - Requester inputs arrive registered, so a requester stays high for one cycle after its ack.
  - On ack, that requester's bit in the hold-off mask is set for exactly 1 cycle; its request is ignored during that cycle.
  - Other requesters are unaffected; back-to-back grants to a different requester are allowed.
- instr_data = low 32 bits of mem_rdata.
- x_data holds its last value between acks.
- Requests changing during BUSY are ignored; latched values are used.
- mem_ack in IDLE is ignored (no ack is generated).
- Simultaneous mem_ack and a new request: the new request is considered in IDLE on the following cycle.
- Reset mid-transaction aborts the access; no ack is issued.

Optional Feature:
- Macro: C2C_ARB_TIMEOUT_EN.
- With the macro: an 8-bit+ counter runs in BUSY_x. After TIMEOUT_CYCLES cycles without mem_ack:
  - mem_req drops.
  - x_ack pulses with data = all-ones (0xFFFF_FFFF).
  - Sticky output port `timeout_err` (out, 1) sets; cleared only by reset.
- Without the macro: no counter and no timeout_err port; BUSY waits indefinitely.

Decomposition:
- Shared package c2c_pkg holds:
  - typedef enum arb_state_t {IDLE, BUSY_I, BUSY_DR, BUSY_DW}
  - typedef struct c2c_req_t {we, sel, addr, wdata}
  - constant REQ_DW/REQ_DR/REQ_I indices
- XLEN comes from pipeline.
- One natural sub-module: c2c_prio_sel, the combinational masked fixed-priority picker (one-hot grant out).

Test Plan:
- Single instr read, addr 0x100, memory acks 2 cycles after mem_req with 0x00000013 -> mem_req=1, mem_we=0, mem_addr=0x100; instr_ack pulses 1 cycle with instr_data=0x13.
- dw_we (addr 0x200, data 0xDEADBEEF, sel 0xF) and dr_re raised in the same cycle -> write granted first (mem_we=1, mem_wdata=0xDEADBEEF), dw_ack pulses; dr is granted next; dr_ack follows.
- instr_re held one cycle after instr_ack (registered lag) -> no second memory access issued for instr in the hold-off cycle.
- All three held continuously with a zero-wait memory -> grants follow dw, dr, instr order with no duplicates; each ack is exactly 1 cycle.
- reset asserted during BUSY_DR -> all outputs 0 immediately (async); no dr_ack; IDLE after release.
- C2C_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, memory never acks -> dr_ack with 0xFFFFFFFF after 4 cycles; timeout_err=1 and remains set.
